// File: rtl/ibex_custom_ctrl_if.sv
// ibex_custom_ctrl_if: request, accelerator and result handshake bundle for ibex_custom_ctrl.
interface ibex_custom_ctrl_if;
    logic        req_valid_i;
    logic [4:0]  req_op_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic        req_ready_o;
    logic        kill_i;
    logic        acc_start_o;
    logic [4:0]  acc_op_o;
    logic [31:0] acc_rs1_o;
    logic [31:0] acc_rs2_o;
    logic        acc_abort_o;
    logic        acc_valid_i;
    logic [31:0] acc_result_i;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        result_err_o;
    logic        result_ready_i;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, kill_i,
        input  acc_valid_i, acc_result_i, result_ready_i,
        output req_ready_o, acc_start_o, acc_op_o, acc_rs1_o, acc_rs2_o, acc_abort_o,
        output result_valid_o, result_o, result_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, kill_i,
        output acc_valid_i, acc_result_i, result_ready_i,
        input  req_ready_o, acc_start_o, acc_op_o, acc_rs1_o, acc_rs2_o, acc_abort_o,
        input  result_valid_o, result_o, result_err_o, busy_o
    );
endinterface

// File: rtl/ibex_custom_ctrl.sv
// ibex_custom_ctrl: issue/sequencing controller for the multi-cycle custom accelerator.
// Define IBEX_CUSTOM_TIMEOUT_EN to abort accelerators that stay silent for TimeoutCycles.
module ibex_custom_ctrl #(
    parameter logic [31:0] OpMask        = 32'h0000_001F,
    parameter int unsigned TimeoutCycles = 64
) (
    input logic               clk_i,
    input logic               rst_ni,
    ibex_custom_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  op_q;
    logic [31:0] rs1_q, rs2_q, result_q;
    logic        err_q, abort_q;
    logic        in_flight, accept, capture, timeout;

    assign in_flight = state_q == ISSUE || state_q == WAIT;
    assign accept    = state_q == IDLE && bus.req_valid_i && !bus.kill_i;
    assign capture   = in_flight && bus.acc_valid_i && !bus.kill_i;

`ifdef IBEX_CUSTOM_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        cnt_max;

    assign cnt_max = cnt_q == 16'(TimeoutCycles - 1);
    assign timeout = state_q == WAIT && cnt_max && !bus.acc_valid_i && !bus.kill_i;

    // Counts WAIT cycles only; saturates rather than wrapping, cleared everywhere else.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= (state_q != WAIT || bus.kill_i) ? 16'd0 : cnt_max ? cnt_q : cnt_q + 16'd1;
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = TimeoutCycles > 0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid_i) state_d = OpMask[bus.req_op_i] ? ISSUE : DONE;
            ISSUE:   state_d = bus.acc_valid_i ? DONE : WAIT;
            WAIT:    if (bus.acc_valid_i || timeout) state_d = DONE;
            DONE:    if (bus.result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= (bus.kill_i && in_flight) || timeout;
            if (accept) begin
                op_q  <= bus.req_op_i;
                rs1_q <= bus.req_rs1_i;
                rs2_q <= bus.req_rs2_i;
                if (!OpMask[bus.req_op_i]) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end
            if (capture) begin
                result_q <= bus.acc_result_i;
                err_q    <= 1'b0;
            end
            if (timeout) begin
                result_q <= 32'hDEAD_0000 | {27'd0, op_q};
                err_q    <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o    = state_q == IDLE;
    assign bus.acc_start_o    = state_q == ISSUE;
    assign bus.acc_op_o       = op_q;
    assign bus.acc_rs1_o      = rs1_q;
    assign bus.acc_rs2_o      = rs2_q;
    assign bus.acc_abort_o    = abort_q;
    assign bus.result_valid_o = state_q == DONE;
    assign bus.result_o       = result_q;
    assign bus.result_err_o   = err_q;
    assign bus.busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_ibex_custom_ctrl.sv
// tb_ibex_custom_ctrl: table-driven transactions plus directed kill/timeout/reset sequences.
module tb_ibex_custom_ctrl;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ibex_custom_ctrl_if bus();

    ibex_custom_ctrl #(.TimeoutCycles(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;
        logic [31:0] res;
        int          hold;
        logic        legal;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        int t, starts, k, ab;
        logic [31:0] held;
        t = -1; starts = 0; k = 0; ab = 0;
        chk("idle_ready", 32'(bus.req_ready_o), 1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = v.op;
        bus.req_rs1_i   = v.rs1;
        bus.req_rs2_i   = v.rs2;
        step();
        bus.req_valid_i = 1'b0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            ab += int'(bus.acc_abort_o);
            if (bus.result_valid_o) k = i;
            else begin
                if (bus.acc_start_o) begin
                    starts++;
                    t = 0;
                    chk("acc_op", 32'(bus.acc_op_o), 32'(v.op));
                    chk("acc_rs1", bus.acc_rs1_o, v.rs1);
                    chk("acc_rs2", bus.acc_rs2_o, v.rs2);
                end else if (t >= 0) t++;
                bus.acc_valid_i  = t == v.lat;
                bus.acc_result_i = bus.acc_valid_i ? v.res : 32'h0BAD_0BAD;
                step();
            end
        end
        chk("latency", k, v.legal ? v.lat + 2 : 1);
        chk("start_count", starts, v.legal ? 1 : 0);
        chk("result", bus.result_o, v.exp_res);
        chk("result_err", 32'(bus.result_err_o), 32'(v.exp_err));
        held = bus.result_o;
        for (int h = 0; h < v.hold; h++) begin
            bus.acc_valid_i  = h == 0;
            bus.acc_result_i = 32'h0BAD_0BAD;
            step();
            ab += int'(bus.acc_abort_o);
            chk("hold_result", bus.result_o, held);
            chk("hold_valid", 32'(bus.result_valid_o), 1);
            chk("hold_ready", 32'(bus.req_ready_o), 0);
        end
        bus.acc_valid_i    = 1'b0;
        bus.result_ready_i = 1'b1;
        step();
        bus.result_ready_i = 1'b0;
        chk("handoff_valid", 32'(bus.result_valid_o), 0);
        chk("handoff_busy", 32'(bus.busy_o), 0);
        chk("no_abort", ab, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, ab, bc, vc;
        vecs[0] = '{5'd1,  32'hCAFE_0001, 32'h0,         3, 32'h1,         1, 1'b1, 32'h1,         1'b0};
        vecs[1] = '{5'd2,  32'h1111_2222, 32'h3333_4444, 0, 32'hA5A5_A5A5, 4, 1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[2] = '{5'd7,  32'hDEAD_BEEF, 32'h1,         0, 32'h0,         2, 1'b0, 32'h0,         1'b1};
        vecs[3] = '{5'd4,  32'h0,         32'hFFFF_FFFF, 1, 32'h1234_5678, 1, 1'b1, 32'h1234_5678, 1'b0};
        vecs[4] = '{5'd31, 32'h7,         32'h8,         0, 32'h0,         1, 1'b0, 32'h0,         1'b1};
        vecs[5] = '{5'd0,  32'hAAAA_5555, 32'h5555_AAAA, 5, 32'hFFFF_FFFF, 1, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{5'd5,  32'h9,         32'h9,         0, 32'h0,         1, 1'b0, 32'h0,         1'b1};
        vecs[7] = '{5'd3,  32'h1,         32'h2,         2, 32'h0,         1, 1'b1, 32'h0,         1'b0};
        bus.req_valid_i = 0; bus.req_op_i = 0; bus.req_rs1_i = 0; bus.req_rs2_i = 0;
        bus.kill_i = 0; bus.acc_valid_i = 0; bus.acc_result_i = 0; bus.result_ready_i = 0;
        #12;
        chk("rst_ready", 32'(bus.req_ready_o), 1);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_valid", 32'(bus.result_valid_o), 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_start", 32'(bus.acc_start_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        for (int i = 0; i < 8; i++) run(vecs[i]);

        // kill in the second WAIT cycle, accelerator answers one cycle too late
        bus.req_valid_i = 1; bus.req_op_i = 5'd1; bus.req_rs1_i = 32'h55; bus.req_rs2_i = 0;
        step();
        bus.req_valid_i = 0;
        chk("kill_issue_start", 32'(bus.acc_start_o), 1);
        step();
        step();
        chk("kill_wait_busy", 32'(bus.busy_o), 1);
        bus.kill_i = 1;
        step();
        bus.kill_i = 0; bus.acc_valid_i = 1; bus.acc_result_i = 32'h77;
        chk("kill_abort", 32'(bus.acc_abort_o), 1);
        chk("kill_valid", 32'(bus.result_valid_o), 0);
        chk("kill_busy", 32'(bus.busy_o), 0);
        run(vecs[3]);

        // kill together with acc_valid in ISSUE: kill wins
        bus.req_valid_i = 1; bus.req_op_i = 5'd2;
        step();
        bus.req_valid_i = 0; bus.kill_i = 1; bus.acc_valid_i = 1; bus.acc_result_i = 32'h9;
        step();
        bus.kill_i = 0; bus.acc_valid_i = 0;
        chk("kill_issue_abort", 32'(bus.acc_abort_o), 1);
        chk("kill_issue_valid", 32'(bus.result_valid_o), 0);
        step();
        chk("abort_single", 32'(bus.acc_abort_o), 0);
        chk("kill_discard", bus.result_o, 32'h1234_5678);

        // request in IDLE with kill is refused; acc_valid in IDLE is ignored
        bus.req_valid_i = 1; bus.req_op_i = 5'd1; bus.kill_i = 1;
        step();
        bus.req_valid_i = 0; bus.kill_i = 0; bus.acc_valid_i = 1; bus.acc_result_i = 32'hFEED;
        chk("idle_kill_busy", 32'(bus.busy_o), 0);
        chk("idle_kill_abort", 32'(bus.acc_abort_o), 0);
        step();
        bus.acc_valid_i = 0;
        chk("idle_accvalid_result", bus.result_o, 32'h1234_5678);
        chk("idle_accvalid_busy", 32'(bus.busy_o), 0);

        // kill in DONE drops the result without abort
        bus.req_valid_i = 1; bus.req_op_i = 5'd7;
        step();
        bus.req_valid_i = 0;
        chk("done_valid", 32'(bus.result_valid_o), 1);
        bus.kill_i = 1;
        step();
        bus.kill_i = 0;
        chk("done_kill_valid", 32'(bus.result_valid_o), 0);
        chk("done_kill_abort", 32'(bus.acc_abort_o), 0);

        // silent accelerator
        bus.req_valid_i = 1; bus.req_op_i = 5'd3; bus.req_rs1_i = 32'h33;
        step();
        bus.req_valid_i = 0;
        ab = 0; bc = 0; vc = 0; k = 0;
`ifdef IBEX_CUSTOM_TIMEOUT_EN
        for (int i = 1; i <= 40 && k == 0; i++) begin
            ab += int'(bus.acc_abort_o);
            if (bus.result_valid_o) k = i;
            else step();
        end
        chk("timeout_latency", k, 10);
        chk("timeout_result", bus.result_o, 32'hDEAD_0003);
        chk("timeout_err", 32'(bus.result_err_o), 1);
        step();
        ab += int'(bus.acc_abort_o);
        chk("timeout_abort_count", ab, 1);
        bus.result_ready_i = 1;
        step();
        bus.result_ready_i = 0;
        chk("timeout_handoff", 32'(bus.busy_o), 0);
`else
        for (int i = 0; i < 100; i++) begin
            bc += int'(bus.busy_o);
            vc += int'(bus.result_valid_o);
            ab += int'(bus.acc_abort_o);
            step();
        end
        chk("hang_busy", bc, 100);
        chk("hang_valid", vc, 0);
        chk("hang_abort", ab, 0);
        bus.kill_i = 1;
        step();
        bus.kill_i = 0;
        chk("hang_kill_abort", 32'(bus.acc_abort_o), 1);
        chk("hang_kill_busy", 32'(bus.busy_o), 0);
`endif
        step();

        // asynchronous reset mid-WAIT
        bus.req_valid_i = 1; bus.req_op_i = 5'd1; bus.req_rs1_i = 32'hCAFE_0001; bus.req_rs2_i = 32'h5;
        step();
        bus.req_valid_i = 0;
        step();
        step();
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.req_ready_o), 1);
        chk("arst_busy", 32'(bus.busy_o), 0);
        chk("arst_abort", 32'(bus.acc_abort_o), 0);
        chk("arst_start", 32'(bus.acc_start_o), 0);
        chk("arst_op", 32'(bus.acc_op_o), 0);
        chk("arst_rs1", bus.acc_rs1_o, 0);
        chk("arst_rs2", bus.acc_rs2_o, 0);
        chk("arst_result", bus.result_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("arst_no_abort", 32'(bus.acc_abort_o), 0);
        run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
